multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main control FSM for the multi-cycle RV datapath; successor to the single-cycle decoder.
//  Sequences FETCH/DECODE/EXECUTE/MEM/WB per instruction from opcode[6:0], with a memory
//  ready handshake, optional I-type ALU support, illegal-opcode trap and a retired-instr counter.
//  Drives PC/IR write enables, ALU operand muxes, ALU op class, memory and register strobes.
// PARAMETERS
//  MEM_WAIT_EN  1   1: memory states wait on mem_ready; 0: mem_ready ignored (treated as 1)
//  ITYPE_EN     1   1: opcode 0010011 (OP-IMM) decoded; 0: treated as illegal
//  TRAP_HALT    1   1: TRAP state held until reset; 0: TRAP lasts 1 cycle, then FETCH
//  CNT_W        16  width of instr_count
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  opcode       in   7      IR[6:0], valid from DECODE onward
//  zero         in   1      ALU zero flag (beq compare)
//  mem_ready    in   1      memory completes current access this cycle
//  pc_write     out  1      PC load enable
//  ir_write     out  1      IR load enable
//  iord         out  1      mem address: 0=PC, 1=ALUOut
//  alu_src_a    out  2      00=PC, 01=rs1(A), 10/11 unused (drive 00)
//  alu_src_b    out  2      00=rs2(B), 01=const 4, 10=imm
//  alu_op       out  2      00=add, 01=sub/branch, 10=R-funct, 11=I-funct
//  pc_src       out  1      0=ALU result, 1=ALUOut (branch target)
//  mem_read     out  1      memory read strobe
//  mem_write    out  1      memory write strobe
//  mem_to_reg   out  1      WB source: 0=ALUOut, 1=MDR
//  reg_write    out  1      register file write enable
//  illegal      out  1      high while in TRAP
//  state        out  4      current state code (debug)
//  instr_count  out  CNT_W  retired instruction count
// BEHAVIOUR
//  States/codes: RST=0 FETCH=1 DECODE=2 MADDR=3 MREAD=4 MWB=5 MWRITE=6 EXR=7 ALUWB=8
//   BRANCH=9 EXI=10 TRAP=11. Outputs are decoded from state (+zero, mem_ready); any output not
//   listed for a state is 0. rst_n low -> state=RST, instr_count=0, all outputs 0.
//  RST: all 0; -> FETCH next cycle (first post-reset cycle is always idle).
//  FETCH: mem_read=1, iord=0, a=00, b=01, op=00; ir_write=pc_write=rdy; stay until rdy -> DECODE.
//   (rdy = mem_ready if MEM_WAIT_EN else 1.)
//  DECODE: a=00, b=10, op=00 (branch target to ALUOut). Next by opcode:
//   0000011/0100011 -> MADDR; 0110011 -> EXR; 1100011 -> BRANCH;
//   0010011 -> EXI if ITYPE_EN else TRAP; anything else -> TRAP.
//  MADDR: a=01, b=10, op=00; -> MREAD if opcode=0000011, else MWRITE.
//  MREAD: mem_read=1, iord=1; wait rdy -> MWB. MWB: reg_write=1, mem_to_reg=1 -> FETCH.
//  MWRITE: mem_write=1, iord=1; wait rdy -> FETCH. mem_write held stable while waiting.
//  EXR: a=01, b=00, op=10 -> ALUWB. EXI: a=01, b=10, op=11 -> ALUWB.
//  ALUWB: reg_write=1, mem_to_reg=0 -> FETCH.
//  BRANCH: a=01, b=00, op=01, pc_src=1, pc_write=zero -> FETCH (1 cycle, taken or not).
//  TRAP: illegal=1; TRAP_HALT ? stay : -> FETCH. Trap never increments instr_count.
//  instr_count: +1 on each transition into FETCH from MWB, MWRITE, ALUWB or BRANCH; wraps
//   modulo 2^CNT_W silently. Latencies (rdy=1): ld 5, sd 4, R/I 4, beq 3 cycles.
//  Async reset mid-instruction (incl. mid-wait) aborts it: strobes drop immediately, no count.
//  opcode/zero/mem_ready sampled only in the states listed; X on them elsewhere is harmless.
// TESTING
//  Reset release, rdy=1, ld opcode 0000011 -> state 0,1,2,3,4,5,1; reg_write+mem_to_reg in 5; count=1.
//  sd 0100011 with mem_ready low 3 cycles in MWRITE -> mem_write high 4 cycles, no reg_write, count+1.
//  beq 1100011 zero=1 -> pc_write=1,pc_src=1 in BRANCH; zero=0 -> pc_write=0; both count+1.
//  Opcode 1111111, TRAP_HALT=1 -> illegal stuck high, count frozen; TRAP_HALT=0 -> 1 cycle, then FETCH.
//  OP-IMM 0010011: ITYPE_EN=1 -> EXR-like path with alu_op=11; ITYPE_EN=0 -> TRAP.
//  CNT_W=4, 16 R-type instrs -> instr_count wraps 15->0; rst_n low in MREAD -> all outputs 0 at once.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV datapath: sequences fetch/decode/execute/mem/wb
// per opcode, with memory-ready wait, optional OP-IMM, illegal-opcode trap and retire counter.
module multicycle_control #(
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter bit          ITYPE_EN    = 1'b1,
  parameter bit          TRAP_HALT   = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             iord,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             pc_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MADDR  = 4'd3,
    S_MREAD  = 4'd4,
    S_MWB    = 4'd5,
    S_MWRITE = 4'd6,
    S_EXR    = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_EXI    = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  state_t cur, nxt;
  logic   rdy;
  logic   retire;

  assign rdy   = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign state = cur;

  always_comb begin
    nxt = cur;
    unique case (cur)
      S_RST:    nxt = S_FETCH;
      S_FETCH:  if (rdy) nxt = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_LOAD, OP_STORE: nxt = S_MADDR;
          OP_REG:            nxt = S_EXR;
          OP_BR:             nxt = S_BRANCH;
          OP_IMM:            nxt = ITYPE_EN ? S_EXI : S_TRAP;
          default:           nxt = S_TRAP;
        endcase
      end
      S_MADDR:  nxt = (opcode == OP_LOAD) ? S_MREAD : S_MWRITE;
      S_MREAD:  if (rdy) nxt = S_MWB;
      S_MWB:    nxt = S_FETCH;
      S_MWRITE: if (rdy) nxt = S_FETCH;
      S_EXR:    nxt = S_ALUWB;
      S_EXI:    nxt = S_ALUWB;
      S_ALUWB:  nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      S_TRAP:   nxt = TRAP_HALT ? S_TRAP : S_FETCH;
      default:  nxt = S_RST;
    endcase
  end

  // Retirement is the hand-off back to FETCH from a completing state; TRAP never retires.
  assign retire = (nxt == S_FETCH) &&
                  (cur == S_MWB || cur == S_MWRITE || cur == S_ALUWB || cur == S_BRANCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= S_RST;
      instr_count <= '0;
    end else begin
      cur <= nxt;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Outputs are decoded from the state register (plus zero/mem_ready), so they follow an
  // async reset at once and the FETCH enables can track mem_ready within the same cycle.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    unique case (cur)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = rdy;
        pc_write  = rdy;
      end
      S_DECODE: alu_src_b = 2'b10;
      S_MADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      S_MREAD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MWRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXR: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b10;
      end
      S_EXI: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b01;
        pc_src    = 1'b1;
        pc_write  = zero;
      end
      S_TRAP: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: two parameterisations, table-driven vectors
// plus hand sequences, with expectations queued at drive time and compared mid-cycle.
module tb_multicycle_control;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] SD = 7'b0100011;
  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] BQ = 7'b1100011;
  localparam logic [6:0] IT = 7'b0010011;
  localparam logic [6:0] XX = 7'b1111111;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic [6:0] opcode = '0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;

  logic        pw_a, iw_a, io_a, pcs_a, mr_a, mw_a, m2r_a, rw_a, il_a;
  logic [1:0]  sa_a, sb_a, op_a;
  logic [3:0]  st_a;
  logic [3:0]  cnt_a;
  logic        pw_b, iw_b, io_b, pcs_b, mr_b, mw_b, m2r_b, rw_b, il_b;
  logic [1:0]  sa_b, sb_b, op_b;
  logic [3:0]  st_b;
  logic [15:0] cnt_b;

  always #5 clk = ~clk;

  multicycle_control #(
    .MEM_WAIT_EN(1'b1), .ITYPE_EN(1'b1), .TRAP_HALT(1'b1), .CNT_W(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_a), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pw_a), .ir_write(iw_a), .iord(io_a), .alu_src_a(sa_a), .alu_src_b(sb_a),
    .alu_op(op_a), .pc_src(pcs_a), .mem_read(mr_a), .mem_write(mw_a), .mem_to_reg(m2r_a),
    .reg_write(rw_a), .illegal(il_a), .state(st_a), .instr_count(cnt_a)
  );

  multicycle_control #(
    .MEM_WAIT_EN(1'b0), .ITYPE_EN(1'b0), .TRAP_HALT(1'b0), .CNT_W(16)
  ) dut_b (
    .clk(clk), .rst_n(rst_b), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pw_b), .ir_write(iw_b), .iord(io_b), .alu_src_a(sa_b), .alu_src_b(sb_b),
    .alu_op(op_b), .pc_src(pcs_b), .mem_read(mr_b), .mem_write(mw_b), .mem_to_reg(m2r_b),
    .reg_write(rw_b), .illegal(il_b), .state(st_b), .instr_count(cnt_b)
  );

  wire [14:0] out_a = {pw_a, iw_a, io_a, sa_a, sb_a, op_a, pcs_a, mr_a, mw_a, m2r_a, rw_a, il_a};
  wire [14:0] out_b = {pw_b, iw_b, io_b, sa_b, sb_b, op_b, pcs_b, mr_b, mw_b, m2r_b, rw_b, il_b};

  typedef struct {
    logic       rst;
    logic [6:0] opc;
    logic       z;
    logic       rdy;
    logic [3:0] st;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    bit          sel;
    logic [3:0]  st;
    logic [14:0] out;
    logic [15:0] cnt;
    int          id;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int vid = 0;

  // Reference output decode: {pc_write, ir_write, iord, a, b, op, pc_src, mem_read,
  // mem_write, mem_to_reg, reg_write, illegal}
  function automatic logic [14:0] exp_out(input logic [3:0] s, input logic z,
                                          input logic rdy, input bit mw);
    logic r;
    r = mw ? rdy : 1'b1;
    case (s)
      4'd1:    exp_out = {r, r, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      4'd2:    exp_out = {3'b000, 2'b00, 2'b10, 2'b00, 6'b000000};
      4'd3:    exp_out = {3'b000, 2'b01, 2'b10, 2'b00, 6'b000000};
      4'd4:    exp_out = {3'b001, 2'b00, 2'b00, 2'b00, 6'b010000};
      4'd5:    exp_out = {3'b000, 2'b00, 2'b00, 2'b00, 6'b000110};
      4'd6:    exp_out = {3'b001, 2'b00, 2'b00, 2'b00, 6'b001000};
      4'd7:    exp_out = {3'b000, 2'b01, 2'b00, 2'b10, 6'b000000};
      4'd8:    exp_out = {3'b000, 2'b00, 2'b00, 2'b00, 6'b000010};
      4'd9:    exp_out = {z, 2'b00, 2'b01, 2'b00, 2'b01, 6'b100000};
      4'd10:   exp_out = {3'b000, 2'b01, 2'b10, 2'b11, 6'b000000};
      4'd11:   exp_out = {3'b000, 2'b00, 2'b00, 2'b00, 6'b000001};
      default: exp_out = '0;
    endcase
  endfunction

  task automatic step(input bit sel, input logic rst, input logic [6:0] opc, input logic z,
                      input logic rdy, input logic [3:0] st, input logic [15:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    if (sel) begin
      rst_a = 1'b0;
      rst_b = rst;
    end else begin
      rst_b = 1'b0;
      rst_a = rst;
    end
    opcode    = opc;
    zero      = z;
    mem_ready = rdy;
    e.sel = sel;
    e.st  = st;
    e.out = exp_out(st, z, rdy, !sel);
    e.cnt = cnt;
    e.id  = vid;
    vid++;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [3:0]  gs;
      logic [14:0] go;
      logic [15:0] gc;
      e  = q.pop_front();
      gs = e.sel ? st_b : st_a;
      go = e.sel ? out_b : out_a;
      gc = e.sel ? cnt_b : {12'd0, cnt_a};
      checks++;
      if (gs !== e.st) begin
        errors++;
        $display("FAIL v%0d state got %0d exp %0d", e.id, gs, e.st);
      end
      checks++;
      if (go !== e.out) begin
        errors++;
        $display("FAIL v%0d outputs got %b exp %b", e.id, go, e.out);
      end
      checks++;
      if (gc !== e.cnt) begin
        errors++;
        $display("FAIL v%0d count got %0d exp %0d", e.id, gc, e.cnt);
      end
    end
  end

  vec_t tbl[35];

  initial begin
    logic [15:0] c;
    tbl[0]  = '{1'b0, LD, 1'b0, 1'b1, 4'd0,  16'd0};
    tbl[1]  = '{1'b1, LD, 1'b0, 1'b1, 4'd0,  16'd0};
    tbl[2]  = '{1'b1, LD, 1'b0, 1'b0, 4'd1,  16'd0};
    tbl[3]  = '{1'b1, LD, 1'b0, 1'b1, 4'd1,  16'd0};
    tbl[4]  = '{1'b1, LD, 1'b0, 1'b1, 4'd2,  16'd0};
    tbl[5]  = '{1'b1, LD, 1'b0, 1'b1, 4'd3,  16'd0};
    tbl[6]  = '{1'b1, LD, 1'b0, 1'b0, 4'd4,  16'd0};
    tbl[7]  = '{1'b1, LD, 1'b0, 1'b1, 4'd4,  16'd0};
    tbl[8]  = '{1'b1, LD, 1'b0, 1'b1, 4'd5,  16'd0};
    tbl[9]  = '{1'b1, SD, 1'b0, 1'b1, 4'd1,  16'd1};
    tbl[10] = '{1'b1, SD, 1'b0, 1'b1, 4'd2,  16'd1};
    tbl[11] = '{1'b1, SD, 1'b0, 1'b1, 4'd3,  16'd1};
    tbl[12] = '{1'b1, SD, 1'b0, 1'b0, 4'd6,  16'd1};
    tbl[13] = '{1'b1, SD, 1'b0, 1'b0, 4'd6,  16'd1};
    tbl[14] = '{1'b1, SD, 1'b0, 1'b0, 4'd6,  16'd1};
    tbl[15] = '{1'b1, SD, 1'b0, 1'b1, 4'd6,  16'd1};
    tbl[16] = '{1'b1, BQ, 1'b0, 1'b1, 4'd1,  16'd2};
    tbl[17] = '{1'b1, BQ, 1'b0, 1'b1, 4'd2,  16'd2};
    tbl[18] = '{1'b1, BQ, 1'b1, 1'b1, 4'd9,  16'd2};
    tbl[19] = '{1'b1, BQ, 1'b0, 1'b1, 4'd1,  16'd3};
    tbl[20] = '{1'b1, BQ, 1'b0, 1'b1, 4'd2,  16'd3};
    tbl[21] = '{1'b1, BQ, 1'b0, 1'b1, 4'd9,  16'd3};
    tbl[22] = '{1'b1, IT, 1'b0, 1'b1, 4'd1,  16'd4};
    tbl[23] = '{1'b1, IT, 1'b0, 1'b1, 4'd2,  16'd4};
    tbl[24] = '{1'b1, IT, 1'b0, 1'b1, 4'd10, 16'd4};
    tbl[25] = '{1'b1, IT, 1'b0, 1'b1, 4'd8,  16'd4};
    tbl[26] = '{1'b1, RT, 1'b0, 1'b1, 4'd1,  16'd5};
    tbl[27] = '{1'b1, RT, 1'b0, 1'b1, 4'd2,  16'd5};
    tbl[28] = '{1'b1, RT, 1'b0, 1'b1, 4'd7,  16'd5};
    tbl[29] = '{1'b1, RT, 1'b0, 1'b1, 4'd8,  16'd5};
    tbl[30] = '{1'b1, XX, 1'b0, 1'b1, 4'd1,  16'd6};
    tbl[31] = '{1'b1, XX, 1'b0, 1'b1, 4'd2,  16'd6};
    tbl[32] = '{1'b1, XX, 1'b0, 1'b1, 4'd11, 16'd6};
    tbl[33] = '{1'b1, LD, 1'b1, 1'b1, 4'd11, 16'd6};
    tbl[34] = '{1'b1, RT, 1'b0, 1'b0, 4'd11, 16'd6};

    for (int i = 0; i < 35; i++)
      step(1'b0, tbl[i].rst, tbl[i].opc, tbl[i].z, tbl[i].rdy, tbl[i].st, tbl[i].cnt);

    // Reset out of the halted trap, then 16 R-type instructions: 4-bit counter wraps to 0.
    step(1'b0, 1'b0, XX, 1'b0, 1'b1, 4'd0, 16'd0);
    step(1'b0, 1'b1, RT, 1'b0, 1'b1, 4'd0, 16'd0);
    for (int i = 0; i < 16; i++) begin
      c = 16'(i);
      step(1'b0, 1'b1, RT, 1'b0, 1'b1, 4'd1, c);
      step(1'b0, 1'b1, RT, 1'b0, 1'b1, 4'd2, c);
      step(1'b0, 1'b1, RT, 1'b1, 1'b1, 4'd7, c);
      step(1'b0, 1'b1, RT, 1'b0, 1'b1, 4'd8, c);
    end
    step(1'b0, 1'b1, LD, 1'b0, 1'b1, 4'd1, 16'd0);

    // One load to bump the count, then async reset while stalled in MREAD.
    step(1'b0, 1'b1, LD, 1'b0, 1'b1, 4'd2, 16'd0);
    step(1'b0, 1'b1, LD, 1'b0, 1'b1, 4'd3, 16'd0);
    step(1'b0, 1'b1, LD, 1'b0, 1'b1, 4'd4, 16'd0);
    step(1'b0, 1'b1, LD, 1'b0, 1'b1, 4'd5, 16'd0);
    step(1'b0, 1'b1, LD, 1'b0, 1'b1, 4'd1, 16'd1);
    step(1'b0, 1'b1, LD, 1'b0, 1'b1, 4'd2, 16'd1);
    step(1'b0, 1'b1, LD, 1'b0, 1'b1, 4'd3, 16'd1);
    step(1'b0, 1'b1, LD, 1'b0, 1'b0, 4'd4, 16'd1);
    step(1'b0, 1'b0, LD, 1'b0, 1'b1, 4'd0, 16'd0);
    step(1'b0, 1'b0, LD, 1'b0, 1'b1, 4'd0, 16'd0);

    // Second instance: no memory wait, OP-IMM illegal, one-cycle trap.
    step(1'b1, 1'b0, LD, 1'b0, 1'b0, 4'd0, 16'd0);
    step(1'b1, 1'b1, LD, 1'b0, 1'b0, 4'd0, 16'd0);
    step(1'b1, 1'b1, LD, 1'b0, 1'b0, 4'd1, 16'd0);
    step(1'b1, 1'b1, LD, 1'b0, 1'b0, 4'd2, 16'd0);
    step(1'b1, 1'b1, LD, 1'b0, 1'b0, 4'd3, 16'd0);
    step(1'b1, 1'b1, LD, 1'b0, 1'b0, 4'd4, 16'd0);
    step(1'b1, 1'b1, LD, 1'b0, 1'b0, 4'd5, 16'd0);
    step(1'b1, 1'b1, IT, 1'b0, 1'b0, 4'd1, 16'd1);
    step(1'b1, 1'b1, IT, 1'b0, 1'b0, 4'd2, 16'd1);
    step(1'b1, 1'b1, IT, 1'b0, 1'b0, 4'd11, 16'd1);
    step(1'b1, 1'b1, XX, 1'b0, 1'b0, 4'd1, 16'd1);
    step(1'b1, 1'b1, XX, 1'b0, 1'b0, 4'd2, 16'd1);
    step(1'b1, 1'b1, SD, 1'b0, 1'b0, 4'd11, 16'd1);
    step(1'b1, 1'b1, SD, 1'b0, 1'b0, 4'd1, 16'd1);
    step(1'b1, 1'b1, SD, 1'b0, 1'b0, 4'd2, 16'd1);
    step(1'b1, 1'b1, SD, 1'b0, 1'b0, 4'd3, 16'd1);
    step(1'b1, 1'b1, SD, 1'b0, 1'b0, 4'd6, 16'd1);
    step(1'b1, 1'b1, BQ, 1'b0, 1'b0, 4'd1, 16'd2);
    step(1'b1, 1'b1, BQ, 1'b0, 1'b0, 4'd2, 16'd2);
    step(1'b1, 1'b1, BQ, 1'b1, 1'b0, 4'd9, 16'd2);
    step(1'b1, 1'b1, RT, 1'b0, 1'b0, 4'd1, 16'd3);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
